// File: rtl/ldtu_ofifo_serializer_if.sv
// Output-stage bundle between the LiTe-DTU output FIFO and the serial links.
// master: serializer side; slave: FIFO/link side.
interface ldtu_ofifo_serializer_if #(
    parameter int unsigned Nbits_32 = 32,
    parameter int unsigned NOUT     = 8
);
    logic                enable;
    logic [Nbits_32-1:0] DATA32_DTU;
    logic                read_signal;
    logic [NOUT-1:0]     ser_out;
    logic                frame_start;
    logic [1:0]          slot_kind;

    modport master (
        input  enable, DATA32_DTU,
        output read_signal, ser_out, frame_start, slot_kind
    );

    modport slave (
        output enable, DATA32_DTU,
        input  read_signal, ser_out, frame_start, slot_kind
    );
endinterface

// File: rtl/ldtu_ofifo_serializer.sv
// Frames FIFO words behind a counted header and slices each 32-bit word into
// NOUT-bit chunks, MSB first, one chunk per CLK.
module ldtu_ofifo_serializer #(
    parameter int unsigned         Nbits_32    = 32,
    parameter int unsigned         NOUT        = 8,
    parameter int unsigned         FRAME_WORDS = 16,
    parameter logic [7:0]          HDR_TAG     = 8'h5A,
    parameter int unsigned         CNT_BITS    = 24,
    parameter logic [Nbits_32-1:0] IDLE_WORD   = 32'hEAAAAAAA
) (
    input  logic                         CLK,
    input  logic                         rst_b,
    ldtu_ofifo_serializer_if.master      bus
);
    localparam int unsigned RATIO = Nbits_32 / NOUT;
    localparam int unsigned PH_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned WC_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    typedef enum logic [1:0] {
        K_IDLE = 2'd0,
        K_HDR  = 2'd1,
        K_DATA = 2'd2
    } kind_t;

    logic [PH_W-1:0]     ph, ph_nx;
    logic [Nbits_32-1:0] shreg, shreg_nx, hdr_word;
    logic [WC_W-1:0]     wcnt, wcnt_nx;
    logic [CNT_BITS-1:0] fcnt, fcnt_nx;
    kind_t               pend, pend_nx, kind_q, kind_nx;
    logic                rd_q, rd_nx, fs_q, fs_nx;
    logic                boundary;

    assign boundary = (ph == PH_W'(RATIO - 1));

    always_comb begin
        hdr_word = '0;
        hdr_word[Nbits_32-1 -: 8] = HDR_TAG;
        hdr_word[CNT_BITS-1:0]    = fcnt;
    end

    always_comb begin
        ph_nx    = ph + 1'b1;
        shreg_nx = shreg << NOUT;
        wcnt_nx  = wcnt;
        fcnt_nx  = fcnt;
        pend_nx  = pend;
        kind_nx  = kind_q;
        rd_nx    = 1'b0;
        fs_nx    = 1'b0;
        if (boundary) begin
            ph_nx   = '0;
            kind_nx = pend;
            unique case (pend)
                K_HDR: begin
                    shreg_nx = hdr_word;
                    fcnt_nx  = fcnt + 1'b1;
                    wcnt_nx  = '0;
                    fs_nx    = 1'b1;
                end
                K_DATA: begin
                    shreg_nx = bus.DATA32_DTU;
                    wcnt_nx  = wcnt + 1'b1;
                end
                default: shreg_nx = IDLE_WORD;
            endcase
            // Successor decision uses the updated word count of the slot just started.
            if (!bus.enable) begin
                pend_nx = K_IDLE;
                wcnt_nx = '0;
            end else if (pend == K_IDLE || wcnt_nx == WC_W'(FRAME_WORDS - 1)) begin
                pend_nx = K_HDR;
            end else begin
                pend_nx = K_DATA;
            end
            rd_nx = (pend_nx == K_DATA);
        end
    end

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            ph     <= '0;
            shreg  <= IDLE_WORD;
            wcnt   <= '0;
            fcnt   <= '0;
            pend   <= K_IDLE;
            kind_q <= K_IDLE;
            rd_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            ph     <= ph_nx;
            shreg  <= shreg_nx;
            wcnt   <= wcnt_nx;
            fcnt   <= fcnt_nx;
            pend   <= pend_nx;
            kind_q <= kind_nx;
            rd_q   <= rd_nx;
            fs_q   <= fs_nx;
        end
    end

    assign bus.ser_out     = shreg[Nbits_32-1 -: NOUT];
    assign bus.read_signal = rd_q;
    assign bus.frame_start = fs_q;
    assign bus.slot_kind   = kind_q;
endmodule

// File: tb/tb_ldtu_ofifo_serializer.sv
// Bench for ldtu_ofifo_serializer: slot-level reference model, a FIFO that
// answers read pulses, and a second instance with a 2-bit frame counter.
module tb_ldtu_ofifo_serializer;
    localparam logic [31:0] IDLE = 32'hEAAAAAAA;
    localparam int FW     = 4;
    localparam int IDLE_K = 0;
    localparam int HDR_K  = 1;
    localparam int DATA_K = 2;

    logic CLK = 1'b0;
    logic rst_b = 1'b0;
    always #5 CLK = ~CLK;

    ldtu_ofifo_serializer_if #(.Nbits_32(32), .NOUT(8)) bus_a ();
    ldtu_ofifo_serializer_if #(.Nbits_32(32), .NOUT(8)) bus_b ();

    ldtu_ofifo_serializer #(
        .Nbits_32(32), .NOUT(8), .FRAME_WORDS(FW), .HDR_TAG(8'h5A),
        .CNT_BITS(24), .IDLE_WORD(32'hEAAAAAAA)
    ) dut_a (.CLK(CLK), .rst_b(rst_b), .bus(bus_a.master));

    ldtu_ofifo_serializer #(
        .Nbits_32(32), .NOUT(8), .FRAME_WORDS(FW), .HDR_TAG(8'h5A),
        .CNT_BITS(2), .IDLE_WORD(32'hEAAAAAAA)
    ) dut_b (.CLK(CLK), .rst_b(rst_b), .bus(bus_b.master));

    int checks, errors;
    logic [31:0] words [256];
    int rdptr;
    bit rd_seen;

    // Reference model state, tracked per slot
    int m_ph, m_cur, m_next, m_ndata, m_dcnt;
    int unsigned m_fcnt, m_fcnt_b;
    logic [31:0] m_word, m_word_b;
    bit m_rd, m_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] chunk(input logic [31:0] w, input int p);
        return w[31-8*p -: 8];
    endfunction

    task automatic model_reset();
        m_ph = 0; m_cur = IDLE_K; m_next = IDLE_K; m_ndata = 0;
        m_fcnt = 0; m_fcnt_b = 0; m_word = IDLE; m_word_b = IDLE;
        m_rd = 0; m_fs = 0; m_dcnt = rdptr;
    endtask

    task automatic model_edge(input bit en);
        if (m_ph == 3) begin
            m_ph = 0;
            m_cur = m_next;
            m_fs = 0;
            case (m_cur)
                HDR_K: begin
                    m_word   = {8'h5A, 24'(m_fcnt)};
                    m_word_b = {8'h5A, 22'd0, 2'(m_fcnt_b)};
                    m_fcnt   = (m_fcnt + 1) % (1 << 24);
                    m_fcnt_b = (m_fcnt_b + 1) % 4;
                    m_ndata  = 0;
                    m_fs     = 1;
                end
                DATA_K: begin
                    m_word   = words[m_dcnt];
                    m_word_b = m_word;
                    m_dcnt++;
                    m_ndata++;
                end
                default: begin
                    m_word   = IDLE;
                    m_word_b = IDLE;
                end
            endcase
            if (!en) begin
                m_next  = IDLE_K;
                m_ndata = 0;
            end else if (m_cur == IDLE_K || m_ndata == FW - 1) begin
                m_next = HDR_K;
            end else begin
                m_next = DATA_K;
            end
            m_rd = (m_next == DATA_K);
        end else begin
            m_ph++;
            m_rd = 0;
            m_fs = 0;
        end
    endtask

    task automatic check_all();
        chk("ser_out_a", 32'(bus_a.ser_out), 32'(chunk(m_word, m_ph)));
        chk("kind_a", 32'(bus_a.slot_kind), 32'(m_cur));
        chk("read_a", 32'(bus_a.read_signal), 32'(m_rd));
        chk("fstart_a", 32'(bus_a.frame_start), 32'(m_fs));
        chk("ser_out_b", 32'(bus_b.ser_out), 32'(chunk(m_word_b, m_ph)));
        chk("kind_b", 32'(bus_b.slot_kind), 32'(m_cur));
        chk("read_b", 32'(bus_b.read_signal), 32'(m_rd));
        chk("fstart_b", 32'(bus_b.frame_start), 32'(m_fs));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ser_a"}, 32'(bus_a.ser_out), 32'h0000_00EA);
        chk({tag, "_read_a"}, 32'(bus_a.read_signal), 32'd0);
        chk({tag, "_kind_a"}, 32'(bus_a.slot_kind), 32'd0);
        chk({tag, "_fs_a"}, 32'(bus_a.frame_start), 32'd0);
        chk({tag, "_ser_b"}, 32'(bus_b.ser_out), 32'h0000_00EA);
        chk({tag, "_read_b"}, 32'(bus_b.read_signal), 32'd0);
    endtask

    // One clock: drive enable, let the edge happen, play FIFO, then compare.
    task automatic tick(input bit en);
        bus_a.enable = en;
        bus_b.enable = en;
        @(posedge CLK);
        #1;
        model_edge(en);
        if (rd_seen) begin
            bus_a.DATA32_DTU = words[rdptr];
            bus_b.DATA32_DTU = words[rdptr];
            rdptr++;
        end
        @(negedge CLK);
        check_all();
        rd_seen = bus_a.read_signal;
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; rdptr = 0; rd_seen = 0;
        for (int i = 0; i < 256; i++) words[i] = $urandom;
        words[0] = 32'h11223344;
        bus_a.enable = 1'b0; bus_b.enable = 1'b0;
        bus_a.DATA32_DTU = IDLE; bus_b.DATA32_DTU = IDLE;
        model_reset();

        // Reset state and idle stream
        #12;
        check_reset_vals("reset");
        @(negedge CLK);
        rst_b = 1'b1;
        repeat (12) tick(1'b0);

        // Framed stream held for several frames (covers 2-bit counter wrap on dut_b)
        repeat (90) tick(1'b1);

        // Drop enable right after the first data read of a frame, then re-enable
        n = 0;
        while (!(m_cur == HDR_K && m_rd) && n < 40) begin tick(1'b1); n++; end
        chk("reach_first_read", 32'(m_cur == HDR_K && m_rd), 32'd1);
        repeat (20) tick(1'b0);
        repeat (24) tick(1'b1);

        // Asynchronous reset at ph=2 of a DATA slot
        n = 0;
        while (!(m_cur == DATA_K && m_ph == 2) && n < 40) begin tick(1'b1); n++; end
        chk("reach_data_ph2", 32'(m_cur == DATA_K && m_ph == 2), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        check_reset_vals("async_rst");
        rd_seen = 0;
        model_reset();
        @(posedge CLK);
        #1;
        check_reset_vals("rst_held");
        @(negedge CLK);
        rst_b = 1'b1;
        check_all();
        repeat (8) tick(1'b0);
        repeat (24) tick(1'b1);

        // Random enable pattern
        repeat (160) tick($urandom_range(0, 3) != 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
